tqv_bus_initiator: RTL

- Bus master for the TinyQV peripheral register interface; it is the initiator side of the address/data_write_n/data_read_n/data_ready protocol that the sprite/video peripherals respond to.
- Converts a valid/ready command stream (from a test sequencer or a DMA-style sprite-table loader) into correctly timed 8/16/32-bit bus writes and reads.
- Returns one response per command, with read-timeout and illegal-size detection.
- Optional write gating lets sprite-register updates land only during vertical blank.

---
 rtl/tqv_bus_initiator_if.sv | 37 +++
 rtl/tqv_bus_initiator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tqv_bus_initiator_if.sv
// Command, peripheral-bus and response signals of the TinyQV bus initiator.
interface tqv_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        gate_en;
    logic        gate;
    logic [5:0]  bus_address;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_write_n;
    logic [1:0]  bus_read_n;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        busy;

    // Initiator side: takes commands and bus returns, drives the bus and responses.
    modport master (
        input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        input  gate_en, gate, bus_rdata, bus_ready,
        output cmd_ready, bus_address, bus_wdata, bus_write_n, bus_read_n,
        output rsp_valid, rsp_rdata, rsp_status, busy
    );

    // Environment side: command source, peripheral and response sink.
    modport slave (
        output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        output gate_en, gate, bus_rdata, bus_ready,
        input  cmd_ready, bus_address, bus_wdata, bus_write_n, bus_read_n,
        input  rsp_valid, rsp_rdata, rsp_status, busy
    );
endinterface

// File: rtl/tqv_bus_initiator.sv
// Initiator for the TinyQV peripheral register bus: one command in, one
// timed bus access out, one response back.
module tqv_bus_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    tqv_bus_initiator_if.master  bif
);
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
    localparam logic [1:0] BUS_IDLE     = 2'b11;
    localparam logic [1:0] ST_WR_OK     = 2'b00;
    localparam logic [1:0] ST_RD_OK     = 2'b01;
    localparam logic [1:0] ST_RD_TMO    = 2'b10;
    localparam logic [1:0] ST_ILLEGAL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_GATE_WAIT, S_WRITE, S_READ, S_RESP
    } state_t;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d, cmd_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              cmd_ready_c, accept_c, timed_out_c;

    logic [ADDR_W-1:0] bus_address_q, bus_address_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]        bus_write_n_q, bus_write_n_d;
    logic [1:0]        bus_read_n_q, bus_read_n_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_status_q, rsp_status_d;

    // Byte lanes that carry data for a given transfer size.
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    assign cmd_ready_c = (state_q == S_IDLE) && !reset;
    assign accept_c    = bif.cmd_valid && cmd_ready_c;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timed_out_c = (state_q == S_READ) && !bif.bus_ready
                         && (cnt_inc == CNT_W'(TIMEOUT));

    assign cmd_in = '{write: bif.cmd_write, size: bif.cmd_size,
                      addr: bif.cmd_addr, wdata: bif.cmd_wdata};

    // State, latched command, read-wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            cnt_q         <= '0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            bus_write_n_q <= BUS_IDLE;
            bus_read_n_q  <= BUS_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_status_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cnt_q         <= cnt_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_write_n_q <= bus_write_n_d;
            bus_read_n_q  <= bus_read_n_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_status_q  <= rsp_status_d;
        end
    end

    // Next state, command latch and read-wait counting.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cmd_d = cmd_in;
                    if (cmd_in.size == SIZE_ILLEGAL) begin
                        state_d = S_RESP;
                    end else if (cmd_in.write && bif.gate_en && !bif.gate) begin
                        state_d = S_GATE_WAIT;
                    end else if (cmd_in.write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = '0;
                    end
                end
            end
            S_GATE_WAIT: begin
                if (bif.gate || !bif.gate_en) state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                if (bif.bus_ready || timed_out_c) state_d = S_RESP;
                else                              cnt_d   = cnt_inc;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs, keyed on the
    // state being entered so each strobe lines up with its state.
    always_comb begin
        bus_write_n_d = BUS_IDLE;
        bus_read_n_d  = BUS_IDLE;
        bus_address_d = '0;
        bus_wdata_d   = '0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_status_d  = rsp_status_q;
        case (state_d)
            S_WRITE: begin
                bus_write_n_d = cmd_d.size;
                bus_address_d = cmd_d.addr;
                bus_wdata_d   = cmd_d.wdata & size_mask(cmd_d.size);
            end
            S_READ: begin
                bus_read_n_d  = cmd_d.size;
                bus_address_d = cmd_d.addr;
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                case (state_q)
                    S_IDLE:  rsp_status_d = ST_ILLEGAL;
                    S_WRITE: rsp_status_d = ST_WR_OK;
                    S_READ: begin
                        if (timed_out_c) begin
                            rsp_status_d = ST_RD_TMO;
                        end else begin
                            rsp_status_d = ST_RD_OK;
                            rsp_rdata_d  = bif.bus_rdata & size_mask(cmd_q.size);
                        end
                    end
                    default: rsp_status_d = rsp_status_q;
                endcase
            end
            default: ;
        endcase
    end

    assign bif.cmd_ready   = cmd_ready_c;
    assign bif.busy        = (state_q != S_IDLE);
    assign bif.bus_address = bus_address_q;
    assign bif.bus_wdata   = bus_wdata_q;
    assign bif.bus_write_n = bus_write_n_q;
    assign bif.bus_read_n  = bus_read_n_q;
    assign bif.rsp_valid   = rsp_valid_q;
    assign bif.rsp_rdata   = rsp_rdata_q;
    assign bif.rsp_status  = rsp_status_q;
endmodule
